// File: rtl/spi_cmd_master_if.sv
// Host-side handshake and SPI pin bundle for spi_cmd_master.
// The master modport is the initiator's view; slave is the host/pin side.
interface spi_cmd_master_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic              sclk;
  logic              mosi;
  logic              cs_n;
  logic              miso;

  modport master (
    input  start, tx_data, miso,
    output busy, done, rx_data, sclk, mosi, cs_n
  );

  modport slave (
    output start, tx_data, miso,
    input  busy, done, rx_data, sclk, mosi, cs_n
  );
endinterface

// File: rtl/spi_cmd_master.sv
// SPI initiator (CPOL=0, CPHA=1, MSB first): one CMD word out, then one RSP word in.
// Optional build macro SPI_MISO_SYNC_EN adds a 2-flop miso synchronizer and lengthens HOLD by 2 cycles.
module spi_cmd_master #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic clk,
  input  logic rst_n,
  spi_cmd_master_if.master bus
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(2 * DATA_W) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] CMD_BITS = BIT_W'(DATA_W);
  localparam logic [BIT_W-1:0] ALL_BITS = BIT_W'(2 * DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GUARD
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [DATA_W-1:0] rx_q;
  logic              sclk_q;
  logic              mosi_q;
  logic              cs_n_q;
  logic              busy_q;
  logic              done_q;
  logic              miso_smp;

`ifdef SPI_MISO_SYNC_EN
  localparam logic [BIT_W-1:0] HOLD_EXT = BIT_W'(2);

  logic miso_p1;
  logic miso_p2;

  // miso stage 1 -> stage 2; the falling-edge sample uses the stage-2 value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_p1 <= 1'b0;
      miso_p2 <= 1'b0;
    end else begin
      miso_p1 <= bus.miso;
      miso_p2 <= miso_p1;
    end
  end

  assign miso_smp = miso_p2;
`else
  localparam logic [BIT_W-1:0] HOLD_EXT = '0;

  assign miso_smp = bus.miso;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_q    <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            tx_sh   <= bus.tx_data;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            sclk_q  <= 1'b1;
            mosi_q  <= tx_sh[DATA_W-1];
            tx_sh   <= tx_sh << 1;
            state   <= SHIFT;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (sclk_q) begin
              // falling edge: only RSP-phase bits are kept
              sclk_q <= 1'b0;
              if (bit_cnt >= CMD_BITS) begin
                rx_sh <= (rx_sh << 1) | DATA_W'(miso_smp);
              end
              bit_cnt <= bit_cnt + 1'b1;
            end else if (bit_cnt == ALL_BITS) begin
              // final low half-period done; bit_cnt is reused to stretch HOLD
              bit_cnt <= '0;
              state   <= HOLD;
            end else begin
              sclk_q <= 1'b1;
              if (bit_cnt < CMD_BITS) begin
                mosi_q <= tx_sh[DATA_W-1];
                tx_sh  <= tx_sh << 1;
              end else begin
                mosi_q <= 1'b0;
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
          end else if (bit_cnt != HOLD_EXT) begin
            bit_cnt <= bit_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            bit_cnt <= '0;
            cs_n_q  <= 1'b1;
            done_q  <= 1'b1;
            rx_q    <= rx_sh;
            state   <= GUARD;
          end
        end
        GUARD: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.cs_n    = cs_n_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_q;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Bench for spi_cmd_master: behavioural SPI responder plus directed and randomized transactions.
// Build with SPI_MISO_SYNC_EN defined to exercise the synchronized-miso variant.
module tb_spi_cmd_master;

  localparam int CD = 4;
  localparam int DW = 8;
`ifdef SPI_MISO_SYNC_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAT = 1 + CD * (2 + 4 * DW) + EXTRA;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;

  spi_cmd_master_if #(.DATA_W(DW)) bus ();

  spi_cmd_master #(.CLK_DIV(CD), .DATA_W(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] reply_of(input logic [7:0] cmd);
    if (cmd == 8'h56)      return 8'h96;
    else if (cmd == 8'h12) return 8'hAA;
    else                   return {cmd[3:0], cmd[7:4]} ^ 8'h3C;
  endfunction

  // Responder + pin monitor, evaluated on the falling clk edge
  int         mon_cyc = 0;
  int         mon_bitn = 0;
  int         mon_rises = 0;
  int         mon_t_rise1 = 0;
  int         mon_t_rise2 = 0;
  int         mon_cs_fall_t = 0;
  int         mon_cs_rise_t = 0;
  int         mon_cs_high = 0;
  logic [7:0] mon_cmd = '0;
  logic [7:0] mon_rsp = '0;
  bit         mon_mosi_rsp_bad = 0;
  logic       prev_cs = 1'b1;
  logic       prev_sclk = 1'b0;

  always @(negedge clk) begin
    mon_cyc++;
    if (prev_cs && !bus.cs_n) begin
      mon_bitn = 0;
      mon_cmd = '0;
      mon_rises = 0;
      mon_mosi_rsp_bad = 0;
      mon_cs_high = mon_cyc - mon_cs_rise_t;
      mon_cs_fall_t = mon_cyc;
    end
    if (!prev_cs && bus.cs_n) begin
      mon_cs_rise_t = mon_cyc;
      bus.miso = 1'b0;
    end
    if (!bus.cs_n) begin
      if (!prev_sclk && bus.sclk) begin
        mon_rises++;
        if (mon_rises == 1) mon_t_rise1 = mon_cyc;
        if (mon_rises == 2) mon_t_rise2 = mon_cyc;
        if (mon_bitn >= DW && mon_bitn < 2 * DW) begin
          bus.miso = mon_rsp[2*DW-1-mon_bitn];
          if (bus.mosi !== 1'b0) mon_mosi_rsp_bad = 1;
        end else begin
          bus.miso = 1'b0;
        end
      end
      if (prev_sclk && !bus.sclk) begin
        if (mon_bitn < DW) mon_cmd = {mon_cmd[6:0], bus.mosi};
        mon_bitn++;
        if (mon_bitn == DW) mon_rsp = reply_of(mon_cmd);
      end
    end
    prev_cs = bus.cs_n;
    prev_sclk = bus.sclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (bus.busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("idle_reached", {31'd0, bus.busy}, 32'd0);
  endtask

  // One transaction from an idle master; optionally pulse start with 0xFF at cycle pulse_at
  task automatic run_txn(input string name, input logic [7:0] tx, input int pulse_at);
    int n;
    bit seen;
    logic [7:0] exp_rx;
    exp_rx = reply_of(tx);
    wait_idle();
    bus.start = 1'b1;
    bus.tx_data = tx;
    @(negedge clk);
    bus.start = 1'b0;
    bus.tx_data = ~tx;
    n = 1;
    seen = 0;
    chk({name, "_busy"}, {31'd0, bus.busy}, 32'd1);
    while (!seen && n < LAT + 40) begin
      if (bus.done === 1'b1) begin
        seen = 1;
      end else begin
        if (n == pulse_at) begin
          bus.start = 1'b1;
          bus.tx_data = 8'hFF;
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
        n++;
      end
    end
    bus.start = 1'b0;
    chk({name, "_done_seen"}, {31'd0, seen}, 32'd1);
    chk({name, "_latency"}, n, LAT);
    chk({name, "_rx_data"}, {24'd0, bus.rx_data}, {24'd0, exp_rx});
    chk({name, "_mosi_cmd"}, {24'd0, mon_cmd}, {24'd0, tx});
    chk({name, "_sclk_rises"}, mon_rises, 2 * DW);
    chk({name, "_mosi_rsp_low"}, {31'd0, mon_mosi_rsp_bad}, 32'd0);
    chk({name, "_cs_n_at_done"}, {31'd0, bus.cs_n}, 32'd1);
    @(negedge clk);
    chk({name, "_done_width"}, {31'd0, bus.done}, 32'd0);
    chk({name, "_rx_hold"}, {24'd0, bus.rx_data}, {24'd0, exp_rx});
  endtask

  initial begin
    int k;
    bit done_bad;
    logic [7:0] rtx;
    bus.start = 1'b0;
    bus.tx_data = '0;
    bus.miso = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", {31'd0, bus.cs_n}, 32'd1);
    chk("rst_sclk", {31'd0, bus.sclk}, 32'd0);
    chk("rst_mosi", {31'd0, bus.mosi}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_rx", {24'd0, bus.rx_data}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_txn("cmd56", 8'h56, -1);
    chk("cs_to_rise", mon_t_rise1 - mon_cs_fall_t, CD);
    chk("sclk_period", mon_t_rise2 - mon_t_rise1, 2 * CD);
    run_txn("cmd12", 8'h12, -1);
    run_txn("ignored_start", 8'h56, 10);

    // Back-to-back: start held high across the end of a transfer
    wait_idle();
    bus.start = 1'b1;
    bus.tx_data = 8'h3A;
    k = 0;
    while (bus.done !== 1'b1 && k < LAT + 40) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_first_rx", {24'd0, bus.rx_data}, {24'd0, reply_of(8'h3A)});
    bus.tx_data = 8'hC5;
    k = 0;
    while (bus.cs_n !== 1'b0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
    chk("b2b_cs_high_min", {31'd0, (mon_cs_high >= CD)}, 32'd1);
    k = 0;
    while (bus.done !== 1'b1 && k < LAT + 40) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_second_rx", {24'd0, bus.rx_data}, {24'd0, reply_of(8'hC5)});

    // Asynchronous reset in the middle of CMD bit 5
    wait_idle();
    bus.start = 1'b1;
    bus.tx_data = 8'h56;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    while (mon_bitn != 5 && k < LAT) begin
      @(negedge clk);
      k++;
    end
    chk("mid_reached_bit5", mon_bitn, 5);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_cs_n", {31'd0, bus.cs_n}, 32'd1);
    chk("mid_rst_sclk", {31'd0, bus.sclk}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_rx", {24'd0, bus.rx_data}, 32'd0);
    done_bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done !== 1'b0) done_bad = 1;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.done !== 1'b0) done_bad = 1;
    end
    chk("mid_rst_no_done", {31'd0, done_bad}, 32'd0);
    run_txn("after_rst", 8'h12, -1);

    for (int i = 0; i < 6; i++) begin
      rtx = 8'($urandom_range(0, 255));
      run_txn("rand", rtx, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
